fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit that sits upstream of the control-unit decoder. It issues word reads to instruction memory and presents each 32-bit instruction with its PC to the decode stage over a valid/ready handshake. It takes the decoder's `pc_src` and the branch/jump target back as a redirect. It prefetches one word ahead, holds one prefetched word while decode is stalled, and discards any in-flight fetch that a taken redirect makes stale.

## Interface
- `ADDR_WIDTH`, 32, width of PC and memory address.
- `RESET_PC`, 0, first fetch address after reset (word aligned).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request. Held with `imem_addr` stable until `imem_ack`.
- `imem_addr`  out  ADDR_WIDTH  word address of the current request.
- `imem_ack`  in  1  response strobe. When high while `imem_req` is high, it completes the request, and `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  instruction to decode.
- `instr_pc`  out  ADDR_WIDTH  PC of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `instr_ready`  in  1  decode accepts. Consume means `instr_valid && instr_ready`.
- `pc_src`  in  1  sampled only on consume. 1 means redirect to `pc_target`.
- `pc_target`  in  ADDR_WIDTH  redirect address. Bits [1:0] are ignored and treated as 0.

## Operation
- Internal registers:
  - `state`.
  - `req_addr`, which drives `imem_addr`.
  - `redir`, the pending target.
  - `pend`, a 32-bit prefetch buffer.
  - The output registers.
- `imem_req` = 1 in FETCH, PREFETCH and DROP; 0 otherwise. It is decoded from registered state only, so it is glitch-free.
- IDLE: the reset state. The next cycle goes to FETCH with `req_addr`=`RESET_PC`.
- FETCH: `instr_valid`=0.
  - On ack: `instr`<=rdata, `instr_pc`<=`req_addr`, `instr_valid`<=1, `req_addr`+=4, go to PREFETCH.
- PREFETCH: `instr_valid`=1 and a request for `instr_pc`+4 is outstanding.
  - Consume, `pc_src`=1: `instr_valid`<=0. With ack, the response is discarded, `req_addr`<=`pc_target`, go to FETCH. Without ack, `redir`<=`pc_target`, go to DROP.
  - Consume, `pc_src`=0, ack: load the output from rdata, `instr_pc`<=`req_addr`, `req_addr`+=4, stay in PREFETCH.
  - Consume, `pc_src`=0, no ack: `instr_valid`<=0, go to FETCH. The same request continues with its address unchanged.
  - No consume, ack: `pend`<=rdata, `req_addr`+=4, go to STALL.
  - No consume, no ack: no change.
- STALL: `imem_req`=0, `instr_valid`=1, and `pend` holds the word at `instr_pc`+4.
  - Consume, `pc_src`=1: `pend` is discarded, `instr_valid`<=0, `req_addr`<=`pc_target`, go to FETCH.
  - Consume, `pc_src`=0: `instr`<=`pend`, `instr_pc`+=4, go to PREFETCH. `req_addr` already points at the following word.
- DROP: `instr_valid`=0 and the stale request is held at its original address.
  - On ack: rdata is discarded, `req_addr`<=`redir`, go to FETCH.
- Arithmetic: all PC adds are modulo 2^ADDR_WIDTH, so an address at the top of the space wraps to 0.
- At most one memory request is outstanding. No instruction is ever delivered twice or skipped, except by redirect.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr`=0, `instr_pc`=`RESET_PC`, `instr_valid`=0.
  - `state`=IDLE, `pend`=0, `redir`=0.
- Reset is asynchronous. Asserting it mid-operation (including in DROP) forces all outputs to their reset values immediately. The abandoned memory request is simply dropped. Fetch restarts at `RESET_PC`.
- Latency:
  - Reset deassert cycle is c0 (IDLE).
  - c1: `imem_req`=1, `imem_addr`=`RESET_PC`.
  - With ack in c1, `instr_valid`=1 in c2.
  - Each memory wait cycle adds one cycle.
- Throughput: 1 instruction per cycle with zero-wait memory and `instr_ready`=1.
- Redirect penalty: at least 1 bubble cycle (the FETCH cycle for the target). DROP adds the remaining wait cycles of the stale request.
- `instr`/`instr_pc` are stable while `instr_valid`=1 and no consume occurs.
- `pc_src` and `pc_target` are ignored in any cycle without a consume.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning rdata=addr|0x13, `instr_ready`=1 -> `instr_pc`=0,4,8,0xC on consecutive cycles from c2, with `instr`=0x13,0x17,0x1B,0x1F.
- Zero-wait memory, `instr_ready` low for 3 cycles while in PREFETCH -> STALL with `imem_req`=0 and `instr_pc` held. On ready, the next `instr_pc`=held+4 appears without a new request for that address.
- Consume at `instr_pc`=0x8 with `pc_src`=1 and `pc_target`=0x43, zero-wait memory -> one bubble cycle, then `instr_pc`=0x40. The word at 0xC is never presented.
- Same redirect with 3-wait-cycle memory -> DROP with `imem_addr`=0xC held until ack, that rdata is discarded, then `imem_addr`=0x40.
- Redirect taken while in STALL -> `pend` is discarded, the next request goes to `pc_target`, and no stale word appears.
- `rst` pulsed in the middle of DROP -> `imem_req` and `instr_valid` drop to 0 in the same cycle. After release, the first request is to `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with one-word prefetch and redirect handling
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_rdata,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  pc_src,
   input  logic [ADDR_WIDTH-1:0] pc_target
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_PREFETCH,
      S_STALL,
      S_DROP
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [ADDR_WIDTH-1:0] redir_q, redir_d;
   logic [31:0]           pend_q, pend_d;
   logic [31:0]           instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic                  instr_valid_q, instr_valid_d;

   logic                  consume;
   logic [ADDR_WIDTH-1:0] target_aligned;

   assign consume        = instr_valid_q && instr_ready;
   assign target_aligned = pc_target & WORD_MASK;

   // Request is decoded from the state register only, so it never glitches.
   assign imem_req    = (state_q == S_FETCH) || (state_q == S_PREFETCH) || (state_q == S_DROP);
   assign imem_addr   = req_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

   // Next-state and datapath updates for the fetch/prefetch/stall/drop sequencing.
   always_comb begin
      state_d       = state_q;
      req_addr_d    = req_addr_q;
      redir_d       = redir_q;
      pend_d        = pend_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;

      case (state_q)
         S_IDLE: begin
            req_addr_d = RESET_PC;
            state_d    = S_FETCH;
         end

         S_FETCH: begin
            if (imem_ack) begin
               instr_d       = imem_rdata;
               instr_pc_d    = req_addr_q;
               instr_valid_d = 1'b1;
               req_addr_d    = req_addr_q + WORD_STEP;
               state_d       = S_PREFETCH;
            end
         end

         S_PREFETCH: begin
            if (consume) begin
               if (pc_src) begin
                  // Outstanding word is stale; either restart now or wait it out in DROP.
                  instr_valid_d = 1'b0;
                  if (imem_ack) begin
                     req_addr_d = target_aligned;
                     state_d    = S_FETCH;
                  end else begin
                     redir_d = target_aligned;
                     state_d = S_DROP;
                  end
               end else if (imem_ack) begin
                  instr_d    = imem_rdata;
                  instr_pc_d = req_addr_q;
                  req_addr_d = req_addr_q + WORD_STEP;
               end else begin
                  // Same request keeps running; FETCH will present it when it lands.
                  instr_valid_d = 1'b0;
                  state_d       = S_FETCH;
               end
            end else if (imem_ack) begin
               pend_d     = imem_rdata;
               req_addr_d = req_addr_q + WORD_STEP;
               state_d    = S_STALL;
            end
         end

         S_STALL: begin
            if (consume) begin
               if (pc_src) begin
                  instr_valid_d = 1'b0;
                  req_addr_d    = target_aligned;
                  state_d       = S_FETCH;
               end else begin
                  instr_d    = pend_q;
                  instr_pc_d = instr_pc_q + WORD_STEP;
                  state_d    = S_PREFETCH;
               end
            end
         end

         S_DROP: begin
            if (imem_ack) begin
               req_addr_d = redir_q;
               state_d    = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         req_addr_q    <= RESET_PC;
         redir_q       <= '0;
         pend_q        <= '0;
         instr_q       <= '0;
         instr_pc_q    <= RESET_PC;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_addr_q    <= req_addr_d;
         redir_q       <= redir_d;
         pend_q        <= pend_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random memory waits and redirects
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] pc_target = '0;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_src      (pc_src),
      .pc_target   (pc_target)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h13;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Memory model: random or fixed wait per request, checks that a request is held until acked.
   int          wait_fixed = 0;
   int          wait_left  = 0;
   bit          busy       = 1'b0;
   logic [31:0] held_addr  = '0;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         busy     = 1'b0;
         imem_ack = 1'b0;
      end else if (imem_req) begin
         if (!busy) begin
            busy      = 1'b1;
            held_addr = imem_addr;
            wait_left = (wait_fixed < 0) ? int'($urandom_range(0, 3)) : wait_fixed;
         end else begin
            chk("addr_stable", imem_addr, held_addr);
         end
         if (wait_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            busy       = 1'b0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_left--;
         end
      end else begin
         if (busy) chk("req_held", 32'(imem_req), 32'd1);
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
      end
   end

   // Random decode-side driver, enabled only in the random phase.
   bit auto_drv = 1'b0;
   always @(posedge clk) begin
      #2;
      if (auto_drv) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         pc_src      = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) pc_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else pc_target = $urandom & 32'h0000_FFFF;
      end
   end

   // Scoreboard monitor: expected PC stream is the program-order walk (pc+4 or redirect target).
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;
   int          n_consume  = 0;
   bit          prev_hold  = 1'b0;
   logic [31:0] prev_instr = '0;
   logic [31:0] prev_pc    = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && instr_valid) begin
            chk("instr_stable", instr, prev_instr);
            chk("pc_stable", instr_pc, prev_pc);
         end
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
               exp_pc = exp_q.pop_front();
               chk("sb_instr_pc", instr_pc, exp_pc);
               chk("sb_instr", instr, mem_word(exp_pc));
               exp_q.push_back(pc_src ? (pc_target & 32'hFFFF_FFFC) : exp_pc + 32'd4);
               n_consume++;
            end
         end
         prev_hold  = instr_valid && !instr_ready;
         prev_instr = instr;
         prev_pc    = instr_pc;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      instr_ready = 1'b0;
      pc_src      = 1'b0;
      cyc();
      exp_q.delete();
      exp_q.push_back(32'h0);
      rst = 1'b0;
   endtask

   task automatic wait_pc(input logic [31:0] pc, input int budget);
      int n;
      n = 0;
      while (!(instr_valid && instr_pc == pc) && n < budget) begin
         cyc();
         n++;
      end
      chk("reach_valid", 32'(instr_valid), 32'd1);
      chk("reach_pc", instr_pc, pc);
   endtask

   initial begin
      int n;
      int c0;

      // Reset values while reset is held.
      #2;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);

      // Start-up latency and zero-wait streaming.
      wait_fixed = 0;
      do_reset();
      instr_ready = 1'b1;
      cyc();
      chk("c1_req", 32'(imem_req), 32'd1);
      chk("c1_addr", imem_addr, 32'h0);
      chk("c1_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("stream_valid", 32'(instr_valid), 32'd1);
         chk("stream_pc", instr_pc, 32'(i * 4));
         chk("stream_instr", instr, 32'(i * 4) + 32'h13);
      end

      // Decode stall: prefetched word parks, request stops.
      instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stall_req", 32'(imem_req), 32'd0);
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_pc", instr_pc, 32'hC);
      end
      instr_ready = 1'b1;
      cyc();
      chk("unstall_pc", instr_pc, 32'h10);
      chk("unstall_instr", instr, 32'h23);
      chk("unstall_addr", imem_addr, 32'h14);

      // Redirect with zero-wait memory: one bubble.
      do_reset();
      instr_ready = 1'b1;
      wait_pc(32'h8, 20);
      pc_src    = 1'b1;
      pc_target = 32'h43;
      cyc();
      pc_src = 1'b0;
      chk("redir_bubble", 32'(instr_valid), 32'd0);
      chk("redir_addr", imem_addr, 32'h40);
      cyc();
      chk("redir_valid", 32'(instr_valid), 32'd1);
      chk("redir_pc", instr_pc, 32'h40);
      chk("redir_instr", instr, 32'h53);

      // Redirect with 3-wait memory: stale request held in DROP.
      wait_fixed = 3;
      do_reset();
      instr_ready = 1'b1;
      wait_pc(32'h8, 60);
      pc_src    = 1'b1;
      pc_target = 32'h43;
      cyc();
      pc_src = 1'b0;
      chk("drop_req", 32'(imem_req), 32'd1);
      chk("drop_addr", imem_addr, 32'hC);
      chk("drop_valid", 32'(instr_valid), 32'd0);
      n = 0;
      while (imem_addr == 32'hC && n < 10) begin
         cyc();
         n++;
      end
      chk("drop_cycles", 32'(n), 32'd3);
      chk("drop_next_addr", imem_addr, 32'h40);
      chk("drop_next_valid", 32'(instr_valid), 32'd0);
      wait_pc(32'h40, 20);
      chk("drop_instr", instr, 32'h53);

      // Redirect taken from STALL.
      wait_fixed = 0;
      do_reset();
      instr_ready = 1'b1;
      wait_pc(32'h4, 20);
      instr_ready = 1'b0;
      cyc();
      chk("sredir_stall_req", 32'(imem_req), 32'd0);
      instr_ready = 1'b1;
      pc_src      = 1'b1;
      pc_target   = 32'h102;
      cyc();
      pc_src = 1'b0;
      chk("sredir_valid", 32'(instr_valid), 32'd0);
      chk("sredir_addr", imem_addr, 32'h100);
      cyc();
      chk("sredir_pc", instr_pc, 32'h100);
      chk("sredir_instr", instr, 32'h113);

      // Asynchronous reset in the middle of DROP.
      wait_fixed = 3;
      do_reset();
      instr_ready = 1'b1;
      wait_pc(32'h8, 60);
      pc_src    = 1'b1;
      pc_target = 32'h80;
      cyc();
      pc_src = 1'b0;
      cyc();
      chk("arst_in_drop", imem_addr, 32'hC);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_valid", 32'(instr_valid), 32'd0);
      chk("arst_addr", imem_addr, 32'h0);
      cyc();
      exp_q.delete();
      exp_q.push_back(32'h0);
      rst = 1'b0;
      cyc();
      chk("arst_c1_req", 32'(imem_req), 32'd1);
      chk("arst_c1_addr", imem_addr, 32'h0);
      wait_pc(32'h0, 20);
      chk("arst_instr", instr, 32'h13);

      // Random traffic against the scoreboard.
      wait_fixed = -1;
      c0 = n_consume;
      for (int s = 0; s < 3; s++) begin
         auto_drv = 1'b0;
         do_reset();
         auto_drv = 1'b1;
         repeat (1500) cyc();
      end
      auto_drv = 1'b0;
      chk("random_progress", 32'(n_consume - c0 > 300), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
